fetch_unit: RTL and testbench
=============================

# fetch_unit

Instruction fetch stage directly upstream of the control unit. Keeps the program counter, issues one-outstanding read requests to instruction memory, and buffers returned words in a two-entry queue (EXEC register plus skid register). It presents the head entry to the control unit as the 16-bit `EXEC` word, holds it under `STALL`, and redirects the program counter on a taken branch, discarding any in-flight or queued instructions.

## Interface
- `ADDR_W`, 16, instruction-memory word-address width
- `RESET_PC`, 0, first fetch address after reset
- `CLOCK`  in  1  rising-edge clock
- `RESET`  in  1  asynchronous, active-low reset
- `IMEM_ADDR`  out  ADDR_W  word address of current request
- `IMEM_REQ`  out  1  read request; held with stable `IMEM_ADDR` until `IMEM_ACK`
- `IMEM_ACK`  in  1  request accepted; `IMEM_RDATA` valid this cycle
- `IMEM_RDATA`  in  16  instruction word
- `STALL`  in  1  control unit not consuming `EXEC` this cycle
- `BR_TAKEN`  in  1  one-cycle redirect pulse
- `BR_TARGET`  in  ADDR_W  redirect address, sampled when `BR_TAKEN`=1
- `EXEC`  out  16  head instruction to control unit
- `EXEC_VALID`  out  1  `EXEC` holds a valid instruction
- `EXEC_PC`  out  ADDR_W  address `EXEC` was fetched from

## Operation
- Consume event: `EXEC_VALID`=1 and `STALL`=0 at a rising edge.
- Queue: `count` 0..2. `next_count` = `count` + accepted ACK − consume. Head is always in `EXEC`; skid shifts into `EXEC` on consume.
- ACK data with queue empty (or emptying on a consume) goes to `EXEC`; otherwise to skid. Overflow is impossible by the launch rule.
- Launch rule: a new request is issued at an edge only when `next_count` ≤ 1.
- PC: `ADDR_W`-bit word counter, +1 per accepted ACK, wraps all-ones → 0.
- States:
  - IDLE: `IMEM_REQ`=0. Goes to REQ when the launch rule holds.
  - REQ: `IMEM_REQ`=1, `IMEM_ADDR`=PC. On ACK, goes to REQ at PC+1 if the launch rule holds, else IDLE.
  - DROP: `IMEM_REQ`=1 at the old address; the response will be discarded. On ACK, goes to REQ at the pending target.
- Redirect (`BR_TAKEN`=1):
  - Flushes the queue: `count`←0, `EXEC_VALID`←0 next cycle. Takes priority over consume and over ACK data capture.
  - PC/pending target ← `BR_TARGET`.
  - IDLE → REQ at target.
  - REQ with no ACK → DROP, since an outstanding request is never withdrawn.
  - REQ with ACK the same cycle → data discarded, REQ at target.
  - DROP with no ACK → stays in DROP, pending target overwritten (last redirect wins).
  - DROP with ACK → REQ at the new target.
- `EXEC`/`EXEC_PC` are stable while `STALL`=1. `EXEC` keeps its last value when invalid.

## Timing
- `RESET`=0 (async): state IDLE, `IMEM_REQ`=0, `IMEM_ADDR`=`RESET_PC`, PC=`RESET_PC`, `count`=0, `EXEC`=16'h0000, `EXEC_VALID`=0, `EXEC_PC`=0. Reset mid-request drops the request immediately; no response is expected afterwards.
- First edge after `RESET` rises: IDLE→REQ, so `IMEM_REQ`=1 in cycle 1.
- Latency: ACK at edge n → `EXEC_VALID`=1 after edge n (queue previously empty).
- Zero-wait memory with no stall: one instruction per cycle, `IMEM_REQ` continuously high.
- Stall: at most two instructions are buffered; `IMEM_REQ` drops once `next_count`=2.
- Redirect at edge n: `EXEC_VALID`=0 after n. The first target instruction is valid the cycle after its ACK; minimum 2 cycles from the redirect edge with zero-wait ACK.

## Test plan
- Reset release, ACK always 1, `STALL`=0 → addresses 0,1,2,… back-to-back; `EXEC`=RDATA one cycle later; `EXEC_PC` tracks the address.
- `STALL`=1 for 5 cycles during streaming → `EXEC` frozen, skid holds one word, `IMEM_REQ` low after 2 buffered; on release, consecutive `EXEC_PC` values with no gap or duplicate.
- `IMEM_ACK` delayed 3 cycles → `IMEM_ADDR` stable and `IMEM_REQ` held high until ACK.
- `BR_TAKEN` with `BR_TARGET`=16'h0040 while a request to 0x0005 is pending → DROP; 0x0005 data never appears on `EXEC`; next request is 0x0040.
- Two redirects (0x0040, then 0x0080) during one DROP, plus a redirect coinciding with an ACK → fetch resumes at 0x0080; the coincident ACK data is discarded.
- PC at 16'hFFFF → next address 16'h0000. `RESET` pulled low mid-request → all outputs return to reset values asynchronously.

Source files
------------

// File: rtl/fetch_unit.sv
`default_nettype none
// ==== fetch_unit : PC, one-outstanding imem request, 2-entry EXEC/skid queue (rev 1.0) ====
module fetch_unit #(
  parameter int                ADDR_W   = 16,
  parameter logic [ADDR_W-1:0] RESET_PC = '0
) (
  input  logic              CLOCK,
  input  logic              RESET,
  output logic [ADDR_W-1:0] IMEM_ADDR,
  output logic              IMEM_REQ,
  input  logic              IMEM_ACK,
  input  logic [15:0]       IMEM_RDATA,
  input  logic              STALL,
  input  logic              BR_TAKEN,
  input  logic [ADDR_W-1:0] BR_TARGET,
  output logic [15:0]       EXEC,
  output logic              EXEC_VALID,
  output logic [ADDR_W-1:0] EXEC_PC
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DROP = 2'd2
  } state_t;

  state_t            state;
  logic [ADDR_W-1:0] pc;
  logic [15:0]       skid;
  logic [ADDR_W-1:0] skid_pc;
  logic [1:0]        count;

  logic              consume;
  logic              ack_data;
  logic [1:0]        next_count;
  logic              launch;
  logic [ADDR_W-1:0] pc_inc;

  assign consume    = EXEC_VALID & ~STALL;
  assign ack_data   = (state == REQ) & IMEM_ACK;
  assign next_count = count + {1'b0, ack_data} - {1'b0, consume};
  assign launch     = (next_count <= 2'd1);
  assign pc_inc     = pc + ADDR_W'(1);

  // In REQ, pc equals IMEM_ADDR; in DROP, pc is the pending redirect target.
  always_ff @(posedge CLOCK or negedge RESET) begin
    if (!RESET) begin
      state      <= IDLE;
      pc         <= RESET_PC;
      IMEM_ADDR  <= RESET_PC;
      IMEM_REQ   <= 1'b0;
      count      <= 2'd0;
      EXEC       <= 16'h0000;
      EXEC_PC    <= '0;
      EXEC_VALID <= 1'b0;
      skid       <= 16'h0000;
      skid_pc    <= '0;
    end else if (BR_TAKEN) begin
      count      <= 2'd0;
      EXEC_VALID <= 1'b0;
      pc         <= BR_TARGET;
      if (state == REQ && !IMEM_ACK) begin
        state <= DROP;
      end else if (state == DROP && !IMEM_ACK) begin
        state <= DROP;
      end else begin
        state     <= REQ;
        IMEM_REQ  <= 1'b1;
        IMEM_ADDR <= BR_TARGET;
      end
    end else begin
      if (consume) begin
        if (count == 2'd2) begin
          EXEC    <= skid;
          EXEC_PC <= skid_pc;
          if (ack_data) begin
            skid    <= IMEM_RDATA;
            skid_pc <= IMEM_ADDR;
          end
        end else if (ack_data) begin
          EXEC    <= IMEM_RDATA;
          EXEC_PC <= IMEM_ADDR;
        end
      end else if (ack_data) begin
        if (count == 2'd0) begin
          EXEC    <= IMEM_RDATA;
          EXEC_PC <= IMEM_ADDR;
        end else begin
          skid    <= IMEM_RDATA;
          skid_pc <= IMEM_ADDR;
        end
      end
      count      <= next_count;
      EXEC_VALID <= (next_count != 2'd0);

      case (state)
        IDLE: begin
          if (launch) begin
            state     <= REQ;
            IMEM_REQ  <= 1'b1;
            IMEM_ADDR <= pc;
          end
        end
        REQ: begin
          if (IMEM_ACK) begin
            pc <= pc_inc;
            if (launch) begin
              IMEM_ADDR <= pc_inc;
            end else begin
              state    <= IDLE;
              IMEM_REQ <= 1'b0;
            end
          end
        end
        DROP: begin
          if (IMEM_ACK) begin
            state     <= REQ;
            IMEM_ADDR <= pc;
          end
        end
        default: begin
          state    <= IDLE;
          IMEM_REQ <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ==== tb_fetch_unit : directed self-checking bench for fetch_unit (rev 1.0) ====
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic [15:0] imem_addr;
  logic        imem_req;
  logic        imem_ack;
  logic [15:0] imem_rdata;
  logic        stall;
  logic        br_taken;
  logic [15:0] br_target;
  logic [15:0] exec_word;
  logic        exec_valid;
  logic [15:0] exec_pc;

  int passed = 0;
  int total  = 0;

  function automatic logic [15:0] word(input logic [15:0] a);
    return a ^ 16'hC3A5;
  endfunction

  assign imem_rdata = word(imem_addr);

  fetch_unit #(.ADDR_W(16), .RESET_PC(16'h0000)) dut (
    .CLOCK(clk), .RESET(rst_n),
    .IMEM_ADDR(imem_addr), .IMEM_REQ(imem_req), .IMEM_ACK(imem_ack), .IMEM_RDATA(imem_rdata),
    .STALL(stall), .BR_TAKEN(br_taken), .BR_TARGET(br_target),
    .EXEC(exec_word), .EXEC_VALID(exec_valid), .EXEC_PC(exec_pc)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; imem_ack = 1'b0; stall = 1'b0; br_taken = 1'b0; br_target = 16'h0;
    step(); step();
    total++; if (imem_req !== 1'b0) $display("FAIL reset_req: got %0b exp 0", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL reset_addr: got %h exp 0000", imem_addr); else passed++;
    total++; if (exec_valid !== 1'b0) $display("FAIL reset_valid: got %0b exp 0", exec_valid); else passed++;
    total++; if (exec_word !== 16'h0000) $display("FAIL reset_exec: got %h exp 0000", exec_word); else passed++;
    total++; if (exec_pc !== 16'h0000) $display("FAIL reset_exec_pc: got %h exp 0000", exec_pc); else passed++;
    rst_n = 1'b1;
    step();
    total++; if (imem_req !== 1'b1) $display("FAIL first_req: got %0b exp 1", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL first_addr: got %h exp 0000", imem_addr); else passed++;
    total++; if (exec_valid !== 1'b0) $display("FAIL first_valid: got %0b exp 0", exec_valid); else passed++;
  endtask

  task automatic test_stream();
    imem_ack = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (exec_valid !== 1'b1) $display("FAIL stream_valid[%0d]: got %0b exp 1", i, exec_valid); else passed++;
      total++; if (exec_pc !== 16'(i)) $display("FAIL stream_pc[%0d]: got %h exp %h", i, exec_pc, 16'(i)); else passed++;
      total++; if (exec_word !== word(16'(i))) $display("FAIL stream_exec[%0d]: got %h exp %h", i, exec_word, word(16'(i))); else passed++;
      total++; if (imem_addr !== 16'(i + 1)) $display("FAIL stream_addr[%0d]: got %h exp %h", i, imem_addr, 16'(i + 1)); else passed++;
      total++; if (imem_req !== 1'b1) $display("FAIL stream_req[%0d]: got %0b exp 1", i, imem_req); else passed++;
    end
  endtask

  task automatic test_stall();
    stall = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      total++; if (exec_pc !== 16'h0004) $display("FAIL stall_pc[%0d]: got %h exp 0004", i, exec_pc); else passed++;
      total++; if (exec_word !== word(16'h0004)) $display("FAIL stall_exec[%0d]: got %h exp %h", i, exec_word, word(16'h0004)); else passed++;
      total++; if (imem_req !== 1'b0) $display("FAIL stall_req[%0d]: got %0b exp 0", i, imem_req); else passed++;
    end
    stall = 1'b0;
    step();
    total++; if (exec_pc !== 16'h0005) $display("FAIL release_skid_pc: got %h exp 0005", exec_pc); else passed++;
    total++; if (exec_word !== word(16'h0005)) $display("FAIL release_skid_exec: got %h exp %h", exec_word, word(16'h0005)); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0006) $display("FAIL release_req: got req=%0b addr=%h exp req=1 addr=0006", imem_req, imem_addr); else passed++;
    for (int i = 6; i < 8; i++) begin
      step();
      total++; if (exec_pc !== 16'(i) || exec_valid !== 1'b1) $display("FAIL release_seq[%0d]: got pc=%h v=%0b exp pc=%h v=1", i, exec_pc, exec_valid, 16'(i)); else passed++;
    end
  endtask

  task automatic test_ack_delay();
    imem_ack = 1'b0;
    step();
    for (int i = 0; i < 3; i++) begin
      step();
      total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0008) $display("FAIL wait_hold[%0d]: got req=%0b addr=%h exp req=1 addr=0008", i, imem_req, imem_addr); else passed++;
      total++; if (exec_valid !== 1'b0) $display("FAIL wait_valid[%0d]: got %0b exp 0", i, exec_valid); else passed++;
    end
    imem_ack = 1'b1;
    step();
    total++; if (exec_valid !== 1'b1 || exec_pc !== 16'h0008) $display("FAIL wait_done: got v=%0b pc=%h exp v=1 pc=0008", exec_valid, exec_pc); else passed++;
    total++; if (exec_word !== word(16'h0008)) $display("FAIL wait_exec: got %h exp %h", exec_word, word(16'h0008)); else passed++;
    total++; if (imem_addr !== 16'h0009) $display("FAIL wait_next_addr: got %h exp 0009", imem_addr); else passed++;
  endtask

  task automatic test_branch_drop();
    rst_n = 1'b0; imem_ack = 1'b0;
    step();
    rst_n = 1'b1; imem_ack = 1'b1;
    step();
    repeat (5) step();
    imem_ack = 1'b0;
    total++; if (imem_addr !== 16'h0005 || imem_req !== 1'b1) $display("FAIL drop_setup: got req=%0b addr=%h exp req=1 addr=0005", imem_req, imem_addr); else passed++;
    br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_taken = 1'b0;
    total++; if (exec_valid !== 1'b0) $display("FAIL drop_flush: got %0b exp 0", exec_valid); else passed++;
    total++; if (imem_req !== 1'b1 || imem_addr !== 16'h0005) $display("FAIL drop_hold: got req=%0b addr=%h exp req=1 addr=0005", imem_req, imem_addr); else passed++;
    step();
    imem_ack = 1'b1;
    step();
    total++; if (exec_valid !== 1'b0) $display("FAIL drop_discard: got %0b exp 0", exec_valid); else passed++;
    total++; if (imem_addr !== 16'h0040) $display("FAIL drop_target: got %h exp 0040", imem_addr); else passed++;
    step();
    total++; if (exec_valid !== 1'b1 || exec_pc !== 16'h0040) $display("FAIL drop_first: got v=%0b pc=%h exp v=1 pc=0040", exec_valid, exec_pc); else passed++;
    total++; if (exec_word !== word(16'h0040)) $display("FAIL drop_first_exec: got %h exp %h", exec_word, word(16'h0040)); else passed++;
  endtask

  task automatic test_multi_redirect();
    imem_ack = 1'b0; br_taken = 1'b1; br_target = 16'h0040;
    step();
    br_target = 16'h0020;
    step();
    total++; if (imem_addr !== 16'h0041 || exec_valid !== 1'b0) $display("FAIL multi_drop: got addr=%h v=%0b exp addr=0041 v=0", imem_addr, exec_valid); else passed++;
    br_target = 16'h0080; imem_ack = 1'b1;
    step();
    br_taken = 1'b0;
    total++; if (imem_addr !== 16'h0080 || exec_valid !== 1'b0) $display("FAIL multi_resume: got addr=%h v=%0b exp addr=0080 v=0", imem_addr, exec_valid); else passed++;
    step();
    total++; if (exec_pc !== 16'h0080 || exec_word !== word(16'h0080)) $display("FAIL multi_first: got pc=%h exec=%h exp pc=0080 exec=%h", exec_pc, exec_word, word(16'h0080)); else passed++;
    br_taken = 1'b1; br_target = 16'h0010;
    step();
    br_taken = 1'b0;
    total++; if (exec_valid !== 1'b0 || imem_addr !== 16'h0010) $display("FAIL coincide: got v=%0b addr=%h exp v=0 addr=0010", exec_valid, imem_addr); else passed++;
    total++; if (exec_word !== word(16'h0080)) $display("FAIL coincide_hold: got %h exp %h", exec_word, word(16'h0080)); else passed++;
    step();
    total++; if (exec_valid !== 1'b1 || exec_pc !== 16'h0010) $display("FAIL coincide_target: got v=%0b pc=%h exp v=1 pc=0010", exec_valid, exec_pc); else passed++;
  endtask

  task automatic test_wrap();
    br_taken = 1'b1; br_target = 16'hFFFE; imem_ack = 1'b1;
    step();
    br_taken = 1'b0;
    step();
    total++; if (exec_pc !== 16'hFFFE || imem_addr !== 16'hFFFF) $display("FAIL wrap_pre: got pc=%h addr=%h exp pc=fffe addr=ffff", exec_pc, imem_addr); else passed++;
    step();
    total++; if (exec_pc !== 16'hFFFF || imem_addr !== 16'h0000) $display("FAIL wrap_addr: got pc=%h addr=%h exp pc=ffff addr=0000", exec_pc, imem_addr); else passed++;
    step();
    total++; if (exec_pc !== 16'h0000 || exec_word !== word(16'h0000)) $display("FAIL wrap_exec: got pc=%h exec=%h exp pc=0000 exec=%h", exec_pc, exec_word, word(16'h0000)); else passed++;
  endtask

  task automatic test_async_reset();
    imem_ack = 1'b0;
    step();
    total++; if (imem_req !== 1'b1 || exec_valid !== 1'b0) $display("FAIL arst_setup: got req=%0b v=%0b exp req=1 v=0", imem_req, exec_valid); else passed++;
    #2;
    rst_n = 1'b0;
    #1;
    total++; if (imem_req !== 1'b0) $display("FAIL arst_req: got %0b exp 0", imem_req); else passed++;
    total++; if (imem_addr !== 16'h0000) $display("FAIL arst_addr: got %h exp 0000", imem_addr); else passed++;
    total++; if (exec_word !== 16'h0000 || exec_pc !== 16'h0000 || exec_valid !== 1'b0) $display("FAIL arst_exec: got exec=%h pc=%h v=%0b exp 0000 0000 0", exec_word, exec_pc, exec_valid); else passed++;
  endtask

  initial begin
    test_reset();
    test_stream();
    test_stall();
    test_ack_delay();
    test_branch_drop();
    test_multi_redirect();
    test_wrap();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
